// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   - stall vector encodings (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//   - exception codes delivered by the MEM stage
//   - sequencer FSM states
//   - saturating counter helper
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_FROM_IF  = 6'b000011;
    localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
    localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
    localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_0009;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// stall_prio_enc: fixed-priority encoder from the four stage stall requests
// to the 6-bit stall vector. A request from a later stage freezes that stage
// and everything upstream of it; MEM has the highest priority.
// Ports:
//   stallreq_if_i/id_i/ex_i/mem_i  per-stage stall requests
//   stall_o                        stall vector (bit0 PC .. bit5 WB)
module stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if_i,
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       stallreq_mem_i,
    output logic [5:0] stall_o
);

    always_comb begin
        if (stallreq_mem_i)      stall_o = STALL_FROM_MEM;
        else if (stallreq_ex_i)  stall_o = STALL_FROM_EX;
        else if (stallreq_id_i)  stall_o = STALL_FROM_ID;
        else if (stallreq_if_i)  stall_o = STALL_FROM_IF;
        else                     stall_o = STALL_NONE;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
//   - arbitrates stage stall requests into the stall vector
//   - on an exception (or ERET) raises a same-cycle flush with redirect PC,
//     then ignores exceptions for SETTLE_CYCLES cycles
//   - counts stalled cycles (saturating)
//   - optional stall watchdog, enabled by defining PIPE_CTRL_WDT_EN
// Ports:
//   clk, rst                 clock (rising), async active-low reset
//   stallreq_if/id/ex/mem    stall requests from the stages
//   excepttype_i             MEM-stage exception code, 0 = none
//   cp0_epc_i                return address used for ERET
//   stall                    stall vector (bit0 PC .. bit5 WB)
//   flush, new_pc            flush strobe and redirect target
//   stall_cycles             saturating count of cycles with stall != 0
//   wdt_timeout              sticky watchdog flag (0 without PIPE_CTRL_WDT_EN)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned WDT_LIMIT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        wdt_timeout
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    // Cleared asynchronously by reset and set on the first edge after
    // release, so every output reads as idle while rst is low.
    logic        active_q;
    logic [5:0]  stall_req;
    logic        exc_valid;
    logic        wdt_fire;

    stall_prio_enc u_stall_prio_enc (
        .stallreq_if_i  (stallreq_if),
        .stallreq_id_i  (stallreq_id),
        .stallreq_ex_i  (stallreq_ex),
        .stallreq_mem_i (stallreq_mem),
        .stall_o        (stall_req)
    );

    assign exc_valid = (excepttype_i != EXC_NONE);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            settle_cnt_q   <= '0;
            stall_cycles_q <= '0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            active_q       <= 1'b1;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        stall_cycles_d = (stall != STALL_NONE) ? sat_inc32(stall_cycles_q)
                                               : stall_cycles_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q <= 4'd1) begin
                    state_d      = ST_RUN;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
        endcase
    end

    // ---------------- output logic ----------------
    // A redirect suppresses the stall vector so the flushed cycle is neither
    // stalled nor counted; a real exception outranks the watchdog.
    always_comb begin
        flush  = 1'b0;
        new_pc = '0;
        stall  = STALL_NONE;
        if (active_q) begin
            if (state_q == ST_RUN && exc_valid) begin
                flush  = 1'b1;
                new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else if (state_q == ST_RUN && wdt_fire) begin
                flush  = 1'b1;
                new_pc = EXC_VECTOR;
            end else begin
                stall  = stall_req;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

`ifdef PIPE_CTRL_WDT_EN
    logic [31:0] wdt_cnt_q, wdt_cnt_d;
    logic        wdt_flag_q;
    logic        wdt_evt;

    // Fires on the cycle that would be the WDT_LIMIT-th consecutive stall.
    assign wdt_fire = (wdt_cnt_q >= WDT_LIMIT - 32'd1) && (stall_req != STALL_NONE);
    assign wdt_evt  = active_q && (state_q == ST_RUN) && !exc_valid && wdt_fire;
    assign wdt_cnt_d = (stall != STALL_NONE) ? sat_inc32(wdt_cnt_q) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_q  <= '0;
            wdt_flag_q <= 1'b0;
        end else begin
            wdt_cnt_q  <= wdt_cnt_d;
            wdt_flag_q <= wdt_flag_q | wdt_evt;
        end
    end

    assign wdt_timeout = wdt_flag_q | wdt_evt;
`else
    logic unused_wdt_limit;

    assign unused_wdt_limit = ^WDT_LIMIT;
    assign wdt_fire         = 1'b0;
    assign wdt_timeout      = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Arbitrates stall requests from IF/ID/EX/MEM into the 6-bit stall vector consumed by the PC register and the stage latches (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
- Handles exceptions and ERET: issues a one-cycle pipeline flush with a redirect PC, then masks exceptions for a settle window.
- Counts stall cycles for performance monitoring.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for all non-ERET exceptions.
- SETTLE_CYCLES, 2, cycles after a flush during which new exceptions are ignored (1..15).
- WDT_LIMIT, 1024, consecutive-stall threshold for the watchdog (Optional Feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (rst==0 resets immediately; release is sampled on clk).
- stallreq_if  in  1  fetch bus wait.
- stallreq_id  in  1  load-use hazard.
- stallreq_ex  in  1  multicycle mul/div busy.
- stallreq_mem  in  1  data bus wait.
- excepttype_i  in  32  exception code from MEM stage; 0 = none.
- cp0_epc_i  in  32  EPC value for ERET.
- stall  out  6  stall vector.
- flush  out  1  flush all stage latches; PC loads new_pc.
- new_pc  out  32  redirect target, valid when flush==1.
- stall_cycles  out  32  count of cycles with stall!=0.
- wdt_timeout  out  1  sticky watchdog flag (0 when feature compiled out).

Behaviour:
- Stall priority, combinational: mem→6'b011111, else ex→6'b001111, else id→6'b000111, else if→6'b000011, else 6'b000000.
- stall is forced to 0 whenever flush==1.
- Stall arbitration is identical in RUN and SETTLE.
- FSM states: RUN, SETTLE. Reset state is RUN.
- RUN:
  - If excepttype_i!=0: flush=1 combinationally this cycle and next state is SETTLE; the settle counter loads SETTLE_CYCLES.
  - new_pc = cp0_epc_i if excepttype_i==32'h0000000e (ERET), else EXC_VECTOR.
  - The redirect is effective at the same rising edge; latency from exception to flush is 0 cycles.
- SETTLE:
  - flush=0 and excepttype_i is ignored.
  - The counter decrements each cycle; at 1, return to RUN.
  - An exception presented on the final SETTLE cycle is dropped. The MEM stage holds a bubble here by construction.
- Simultaneous exception and stall request: the flush wins, stall=0, and the stall request is not counted.
- new_pc is 0 when flush==0.
- stall_cycles increments by 1 on every edge where stall!=0. It saturates at 32'hFFFFFFFF with no wrap.
- Reset values: stall=0, flush=0, new_pc=0, stall_cycles=0, wdt_timeout=0, state=RUN, counters=0.
- Reset asserted mid-SETTLE or mid-stall: all state clears immediately and asynchronously. After reset, the first cycle is RUN.
- new_pc is 32 bits; no alignment check, since the exception source guarantees word alignment.

Optional Feature:
- Macro: PIPE_CTRL_WDT_EN.
- When defined:
  - A consecutive-stall counter increments while stall!=0 and clears on any cycle with stall==0.
  - On reaching WDT_LIMIT, in RUN state: flush=1, new_pc=EXC_VECTOR, go to SETTLE, and set wdt_timeout (sticky until reset).
  - The watchdog event has lower priority than a real exception in the same cycle; the counter still clears.
- When undefined: no counter logic, wdt_timeout tied to 0.

Decomposition:
- Shared package/define file holds:
  - stall encodings: STALL_NONE, STALL_FROM_IF/ID/EX/MEM;
  - exception codes: EXC_INT=1, EXC_SYSCALL=8, EXC_INVALID=9, EXC_TRAP=0xa, EXC_OV=0xc, EXC_ERET=0xe;
  - FSM state constants.
- One natural sub-module, stall_prio_enc: the combinational priority encoder from the four requests to the stall vector. The FSM, counters and watchdog stay in pipe_ctrl.

Test Plan:
- Reset with stallreq_mem=1 → stall=0, flush=0, stall_cycles=0. Release rst → stall=6'b011111 and stall_cycles increments each cycle.
- stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111. Drop ex → 6'b000111. Drop all → 0; stall_cycles equals the number of stalled cycles.
- excepttype_i=8 for one cycle with stallreq_ex=1 → same cycle: flush=1, new_pc=32'h20, stall=0. Next 2 cycles: SETTLE, flush=0.
- excepttype_i=0xe, cp0_epc_i=32'h0000_1234 → flush=1, new_pc=32'h1234. A second exception 1 cycle later → no flush. Another 2 cycles after SETTLE ends → flush=1.
- rst pulsed low mid-SETTLE (asynchronously, between edges) → outputs clear without waiting for an edge. An exception right after release is flushed normally.
- PIPE_CTRL_WDT_EN with WDT_LIMIT=8 and stallreq_mem held high → on the 8th stalled cycle: flush=1, new_pc=32'h20, wdt_timeout=1 (stays 1). Without the macro → wdt_timeout=0 and no flush.
